// File: rtl/uart_tx_sequencer.sv
// UART transmit framing sequencer: start bit, 8 data bits LSB first, optional even
// parity, stop bit; each bit spans OVERSAMPLE sample_enable ticks from the baud generator.
module uart_tx_sequencer #(
  parameter int OVERSAMPLE = 16,
  parameter bit PARITY_EN  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_en,
  input  logic       tx_wr,
  input  logic [7:0] tx_data,
  input  logic       sample_enable,
  output logic       baud_hold,
  output logic       tx_out,
  output logic       tx_busy,
  output logic       tx_done,
  output logic [2:0] fsm_state
);

  localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [CW-1:0] LAST_TICK = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] tick, tick_d;
  logic [2:0]    idx, idx_d;
  logic [7:0]    shift_reg, shift_d;
  logic          tx_out_d, busy_d, done_d, hold_d;
  logic          advance;

  assign advance   = sample_enable && (tick == LAST_TICK);
  assign fsm_state = state;

  always_comb begin
    state_d  = state;
    tick_d   = tick;
    idx_d    = idx;
    shift_d  = shift_reg;
    done_d   = 1'b0;
    tx_out_d = 1'b1;
    if (state == IDLE) begin
      // ticks arriving while idle never reach the counter
      tick_d = '0;
      idx_d  = 3'd0;
      if (tx_en && tx_wr) begin
        state_d = START;
        shift_d = tx_data;
      end
    end else if (!tx_en) begin
      state_d = IDLE;
      tick_d  = '0;
      idx_d   = 3'd0;
    end else begin
      if (sample_enable) tick_d = tick + 1'b1;
      if (advance) begin
        tick_d = '0;
        case (state)
          START: state_d = DATA;
          DATA: begin
            idx_d = idx + 3'd1;
            if (idx == 3'd7) state_d = PARITY_EN ? PARITY : STOP;
          end
          PARITY: state_d = STOP;
          STOP: begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
          default: state_d = IDLE;
        endcase
      end
    end
    // serial outputs are registered, so they are derived from the next state
    case (state_d)
      START:   tx_out_d = 1'b0;
      DATA:    tx_out_d = shift_d[idx_d];
      PARITY:  tx_out_d = ^shift_d;
      default: tx_out_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
    hold_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      tick      <= '0;
      idx       <= 3'd0;
      shift_reg <= 8'd0;
      tx_out    <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
      baud_hold <= 1'b1;
    end else begin
      state     <= state_d;
      tick      <= tick_d;
      idx       <= idx_d;
      shift_reg <= shift_d;
      tx_out    <= tx_out_d;
      tx_busy   <= busy_d;
      tx_done   <= done_d;
      baud_hold <= hold_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Bench for uart_tx_sequencer: a parity and a no-parity instance share stimulus; frame
// monitors decode tx_out mid-bit and compare against expected frames queued by the driver.
module tb_uart_tx_sequencer;

  localparam int OS = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       tx_en;
  logic       tx_wr;
  logic [7:0] tx_data;
  logic       sample_enable;

  logic       baud_hold, tx_out, tx_busy, tx_done;
  logic [2:0] fsm_state;
  logic       np_baud_hold, np_tx_out, np_tx_busy, np_tx_done;
  logic [2:0] np_fsm_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [10:0] exp_q[$];
  logic [10:0] exp_np_q[$];

  int cyc = 0;
  int se_div = 1;
  int div_cnt = 0;
  int wr_cycle = 0;

  logic        mon_active[2] = '{1'b0, 1'b0};
  int          pulses[2] = '{0, 0};
  logic [10:0] bits[2];
  int          done_cycle[2] = '{0, 0};
  int          done_count[2] = '{0, 0};
  int          abort_count[2] = '{0, 0};
  logic        mon_busy[2], mon_done[2], mon_out[2];

  uart_tx_sequencer #(.OVERSAMPLE(OS), .PARITY_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .tx_en(tx_en), .tx_wr(tx_wr), .tx_data(tx_data),
    .sample_enable(sample_enable), .baud_hold(baud_hold), .tx_out(tx_out),
    .tx_busy(tx_busy), .tx_done(tx_done), .fsm_state(fsm_state)
  );

  uart_tx_sequencer #(.OVERSAMPLE(OS), .PARITY_EN(1'b0)) dut_np (
    .clk(clk), .reset(reset), .tx_en(tx_en), .tx_wr(tx_wr), .tx_data(tx_data),
    .sample_enable(sample_enable), .baud_hold(np_baud_hold), .tx_out(np_tx_out),
    .tx_busy(np_tx_busy), .tx_done(np_tx_done), .fsm_state(np_fsm_state)
  );

  // clock / reset-independent housekeeping
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // sample_enable is high one cycle out of every se_div
  always @(posedge clk) begin
    #1;
    div_cnt = (div_cnt + 1 >= se_div) ? 0 : div_cnt + 1;
    sample_enable = (div_cnt == 0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // frame monitors: count ticks while busy, sample each bit at its mid tick
  always @(negedge clk) begin
    mon_busy[0] = tx_busy;    mon_done[0] = tx_done;    mon_out[0] = tx_out;
    mon_busy[1] = np_tx_busy; mon_done[1] = np_tx_done; mon_out[1] = np_tx_out;
    for (int k = 0; k < 2; k++) begin
      if (!mon_active[k] && mon_busy[k]) begin
        mon_active[k] = 1'b1;
        pulses[k] = 0;
        bits[k] = '0;
      end
      if (mon_active[k]) begin
        if (mon_done[k]) begin
          mon_active[k] = 1'b0;
          done_count[k]++;
          done_cycle[k] = cyc;
          if (k == 0) begin
            check("pulse_count", pulses[k], 11 * OS);
            if (exp_q.size() == 0) check("unexpected_frame", 1, 0);
            else check("frame", bits[k], exp_q.pop_front());
          end else begin
            check("np_pulse_count", pulses[k], 10 * OS);
            if (exp_np_q.size() == 0) check("np_unexpected_frame", 1, 0);
            else check("np_frame", bits[k], exp_np_q.pop_front());
          end
        end else if (!mon_busy[k]) begin
          mon_active[k] = 1'b0;
          abort_count[k]++;
        end else if (sample_enable) begin
          if (pulses[k] % OS == OS / 2) bits[k][pulses[k] / OS] = mon_out[k];
          pulses[k]++;
        end
      end
    end
  end

  // call at a falling edge; returns just after the accepting rising edge
  task automatic write_byte(input logic [7:0] d, input bit complete);
    tx_data = d;
    tx_wr = 1'b1;
    @(posedge clk);
    #1;
    tx_wr = 1'b0;
    wr_cycle = cyc;
    if (complete) begin
      exp_q.push_back({1'b1, ^d, d, 1'b0});
      exp_np_q.push_back({1'b0, 1'b1, d, 1'b0});
    end
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp_np_q.size() != 0 || mon_active[0] || mon_active[1])
           && n < budget) begin
      @(negedge clk);
      #2;
      n++;
    end
    check("drain_in_budget", (n < budget), 1);
    @(negedge clk);
  endtask

  task automatic align_to_tick();
    int n;
    n = 0;
    while (!sample_enable && n < 16) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, done0, ab0, ab1;
    reset = 1'b1;
    tx_en = 1'b1;
    tx_wr = 1'b0;
    tx_data = 8'h00;
    sample_enable = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx_out", tx_out, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_done", tx_done, 0);
    check("rst_hold", baud_hold, 1);
    check("rst_state", fsm_state, 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // 0xA5 with ticks every cycle: 176-cycle frame (160 without parity)
    write_byte(8'hA5, 1'b1);
    check("start_out", tx_out, 0);
    check("start_busy", tx_busy, 1);
    check("start_hold", baud_hold, 0);
    wait_drain(400);
    check("latency_a5", done_cycle[0] - wr_cycle, 176);
    check("np_latency_a5", done_cycle[1] - wr_cycle, 160);

    write_byte(8'h01, 1'b1);
    wait_drain(400);

    // second write mid-frame must be dropped
    write_byte(8'h3C, 1'b1);
    repeat (50) @(negedge clk);
    write_byte(8'hFF, 1'b0);
    wait_drain(400);

    // back-to-back: next write lands in the tx_done cycle
    write_byte(8'hC3, 1'b1);
    n = 0;
    while (!tx_done && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("b2b_done_seen", (n < 400), 1);
    write_byte(8'h55, 1'b1);
    check("done_one_cycle", tx_done, 0);
    check("b2b_busy", tx_busy, 1);
    check("b2b_start", tx_out, 0);
    wait_drain(400);

    // abort by tx_en while sending data bit 3 (0x92 has bit 3 clear)
    done0 = done_count[0];
    ab0 = abort_count[0];
    ab1 = abort_count[1];
    write_byte(8'h92, 1'b0);
    repeat (70) @(negedge clk);
    check("abort_in_data", fsm_state, 2);
    check("abort_bit3", tx_out, 0);
    tx_en = 1'b0;
    @(posedge clk);
    #1;
    check("abort_tx_out", tx_out, 1);
    check("abort_busy", tx_busy, 0);
    check("abort_hold", baud_hold, 1);
    check("abort_done", tx_done, 0);
    check("abort_state", fsm_state, 0);
    tx_en = 1'b1;
    repeat (200) @(negedge clk);
    check("abort_no_done", done_count[0], done0);
    check("abort_seen", abort_count[0], ab0 + 1);
    check("np_abort_seen", abort_count[1], ab1 + 1);

    // reset mid-frame with a tick every 4th cycle
    se_div = 4;
    repeat (8) @(negedge clk);
    align_to_tick();
    write_byte(8'h77, 1'b0);
    repeat (100) @(negedge clk);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("arst_tx_out", tx_out, 1);
    check("arst_busy", tx_busy, 0);
    check("arst_done", tx_done, 0);
    check("arst_hold", baud_hold, 1);
    check("arst_state", fsm_state, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    align_to_tick();
    write_byte(8'h80, 1'b1);
    wait_drain(2000);
    check("latency_80", done_cycle[0] - wr_cycle, 704);
    check("np_latency_80", done_cycle[1] - wr_cycle, 640);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
